// File: rtl/my_spi_master.sv
// SPI mode-0 initiator: one 32-bit frame per request ({wr, addr, wdata}), MSB first,
// capturing the 16-bit data phase from MISO into rdata at the end of the frame.
module my_spi_master #(
    parameter int HALF_PERIOD = 8
) (
    input  logic        theClock,
    input  logic        theReset,
    input  logic        start,
    input  logic        wr,
    input  logic [14:0] addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    output logic        spi_clk,
    output logic        spi_cs,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int            HW     = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hcnt_q;
    logic [4:0]    bitcnt_q;
    logic [31:0]   tx_q;
    logic [15:0]   rx_q;
    logic [15:0]   rdata_q;
    logic          done_q;
    logic          phase_end;
    logic          accept;
    logic          enter_high;
    logic          enter_low;

    assign phase_end  = (hcnt_q == H_LAST);
    assign accept     = (state_q == S_IDLE) && start;
    assign enter_high = (state_d == S_HIGH) && (state_q != S_HIGH);
    assign enter_low  = (state_d == S_LOW) && (state_q != S_LOW);

    always_ff @(posedge theClock or negedge theReset) begin
        if (!theReset) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // bitcnt wrapping to zero during LOW marks the 32nd bit just went out
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)     state_d = S_SETUP;
            S_SETUP: if (phase_end) state_d = S_HIGH;
            S_HIGH:  if (phase_end) state_d = S_LOW;
            S_LOW:   if (phase_end) state_d = (bitcnt_q == 5'd0) ? S_GAP : S_HIGH;
            S_GAP:   if (phase_end) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge theClock or negedge theReset) begin
        if (!theReset) begin
            hcnt_q   <= '0;
            bitcnt_q <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            hcnt_q <= (state_q == S_IDLE || phase_end) ? '0 : hcnt_q + 1'b1;
            done_q <= (state_q == S_GAP) && phase_end;
            if (accept) begin
                tx_q     <= {wr, addr, wr ? wdata : 16'h0000};
                bitcnt_q <= '0;
            end
            // only the second half of the frame carries slave data
            if (enter_high) begin
                if (bitcnt_q[4]) rx_q <= {rx_q[14:0], spi_miso};
                bitcnt_q <= bitcnt_q + 5'd1;
            end
            if (enter_low) tx_q <= {tx_q[30:0], 1'b0};
            if ((state_q == S_GAP) && phase_end) rdata_q <= rx_q;
        end
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        spi_cs   = 1'b1;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        done     = done_q;
        rdata    = rdata_q;
        if (state_q == S_SETUP || state_q == S_HIGH || state_q == S_LOW) begin
            spi_cs   = 1'b0;
            spi_mosi = tx_q[31];
        end
        if (state_q == S_HIGH) spi_clk = 1'b1;
    end

endmodule

// File: tb/tb_my_spi_master.sv
// Bench for my_spi_master: a behavioural register-file slave on the bus, frame/timing
// checks against cycle formulas, and a second HALF_PERIOD=4 instance for edge timing.
module tb_my_spi_master;

    localparam int HP  = 8;
    localparam int HP4 = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start, wr, busy, done, sck, cs, mosi;
    logic        miso = 1'b0;
    logic [14:0] addr;
    logic [15:0] wdata, rdata;
    logic        start4, wr4, busy4, done4, sck4, cs4, mosi4;
    logic [14:0] addr4;
    logic [15:0] wdata4, rdata4;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    my_spi_master #(.HALF_PERIOD(HP)) dut (
        .theClock(clk), .theReset(rst_n), .start(start), .wr(wr), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .spi_clk(sck), .spi_cs(cs), .spi_mosi(mosi),
        .spi_miso(miso)
    );

    my_spi_master #(.HALF_PERIOD(HP4)) dut4 (
        .theClock(clk), .theReset(rst_n), .start(start4), .wr(wr4), .addr(addr4), .wdata(wdata4),
        .busy(busy4), .done(done4), .rdata(rdata4), .spi_clk(sck4), .spi_cs(cs4), .spi_mosi(mosi4),
        .spi_miso(1'b0)
    );

    // Slave model: registers indexed by the low address byte; a frame commits only if
    // all 32 bits arrived before CS rose. Read data is presented after rise 15.
    logic [15:0] sregs   [256];
    logic [15:0] ref_regs[256];
    logic [31:0] frame, last_frame;
    logic [15:0] cur;
    logic        prev_cs = 1'b1, prev_sck = 1'b0;
    int          nr, nf, last_nr, cs_falls = 0, cs_fall_cyc, cs_rise_cyc, done_cnt = 0;
    int          rise_cyc[32], fall_cyc[32];

    always @(negedge clk) begin
        if (prev_cs && !cs) begin
            cs_fall_cyc = cyc; cs_falls++; nr = 0; nf = 0; frame = '0; miso = 1'b0;
        end
        if (!prev_cs && cs) begin
            cs_rise_cyc = cyc; last_frame = frame; last_nr = nr;
            if (nr == 32 && frame[31]) sregs[frame[23:16]] = frame[15:0];
        end
        if (!cs && !prev_sck && sck) begin
            if (nr < 32) rise_cyc[nr] = cyc;
            frame = {frame[30:0], mosi};
            if (nr == 15) cur = sregs[frame[7:0]];
            miso = (nr >= 15 && nr <= 30) ? cur[30-nr] : 1'b0;
            nr++;
        end
        if (prev_sck && !sck) begin
            if (nf < 32) fall_cyc[nf] = cyc;
            nf++;
        end
        if (done) done_cnt++;
        prev_cs  = cs;
        prev_sck = sck;
    end

    task automatic preset(input int a, input logic [15:0] v);
        sregs[a]    = v;
        ref_regs[a] = v;
    endtask

    task automatic launch(input logic w, input logic [14:0] a, input logic [15:0] d, output int t0);
        @(negedge clk);
        start = 1'b1; wr = w; addr = a; wdata = d;
        @(posedge clk);
        #1 start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int t0, output bit ok, output int rel);
        ok = 1'b0;
        rel = 0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; rel = cyc - t0 + 1; break; end
        end
        #1;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #2;
        n_chk++; if ({cs, sck, mosi, busy, done} !== 5'b10000) begin
            n_fail++; $display("FAIL reset_ctl got cs/sck/mosi/busy/done=%b want 10000", {cs, sck, mosi, busy, done});
        end
        n_chk++; if (rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0000", rdata); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write;
        int t0, rel; bit ok;
        preset(2, 16'h3C3C);
        launch(1'b1, 15'h0002, 16'h00A5, t0);
        wait_done(t0, ok, rel);
        n_chk++; if (!ok || rel != 1 + 66*HP) begin n_fail++; $display("FAIL wr_done_cycle got %0d ok=%0b want %0d", rel, ok, 1 + 66*HP); end
        n_chk++; if (last_frame !== 32'h800200A5) begin n_fail++; $display("FAIL wr_frame got %h want 800200a5", last_frame); end
        n_chk++; if (last_nr != 32) begin n_fail++; $display("FAIL wr_rises got %0d want 32", last_nr); end
        n_chk++; if (cs_fall_cyc - t0 + 1 != 1) begin n_fail++; $display("FAIL wr_cs_fall got %0d want 1", cs_fall_cyc - t0 + 1); end
        n_chk++; if (cs_rise_cyc - t0 + 1 != 1 + 65*HP) begin n_fail++; $display("FAIL wr_cs_rise got %0d want %0d", cs_rise_cyc - t0 + 1, 1 + 65*HP); end
        for (int n = 0; n < 32; n++) begin
            n_chk++; if (rise_cyc[n] - t0 + 1 != 1 + (2*n + 1)*HP) begin
                n_fail++; $display("FAIL wr_rise%0d got %0d want %0d", n, rise_cyc[n] - t0 + 1, 1 + (2*n + 1)*HP);
            end
            n_chk++; if (fall_cyc[n] - t0 + 1 != 1 + (2*n + 2)*HP) begin
                n_fail++; $display("FAIL wr_fall%0d got %0d want %0d", n, fall_cyc[n] - t0 + 1, 1 + (2*n + 2)*HP);
            end
        end
        ref_regs[2] = 16'h00A5;
        n_chk++; if (rdata !== 16'h3C3C) begin n_fail++; $display("FAIL wr_rdata got %h want 3c3c", rdata); end
        n_chk++; if (sregs[2] !== ref_regs[2]) begin n_fail++; $display("FAIL wr_commit got %h want %h", sregs[2], ref_regs[2]); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_in_done got %b want 0", busy); end
    endtask

    task automatic test_read;
        int t0, rel; bit ok;
        preset(16, 16'h1234);
        launch(1'b0, 15'h0010, 16'($urandom), t0);
        wait_done(t0, ok, rel);
        n_chk++; if (!ok || rel != 1 + 66*HP) begin n_fail++; $display("FAIL rd_done_cycle got %0d want %0d", rel, 1 + 66*HP); end
        n_chk++; if (last_frame !== 32'h00100000) begin n_fail++; $display("FAIL rd_frame got %h want 00100000", last_frame); end
        n_chk++; if (rdata !== 16'h1234) begin n_fail++; $display("FAIL rd_rdata got %h want 1234", rdata); end
        repeat (20) @(negedge clk);
        n_chk++; if (rdata !== 16'h1234 || done !== 1'b0) begin n_fail++; $display("FAIL rd_hold got %h done=%b want 1234 done=0", rdata, done); end
    endtask

    task automatic test_loopback;
        int t0, rel; bit ok;
        launch(1'b1, 15'h0003, 16'h005A, t0);
        wait_done(t0, ok, rel);
        ref_regs[3] = 16'h005A;
        n_chk++; if (sregs[3] !== 16'h005A) begin n_fail++; $display("FAIL lb_led_reg got %h want 005a", sregs[3]); end
        launch(1'b0, 15'h0003, 16'h0000, t0);
        wait_done(t0, ok, rel);
        n_chk++; if (!ok || rdata !== 16'h005A) begin n_fail++; $display("FAIL lb_led_read got %h want 005a", rdata); end
        preset(1, 16'h01C3);
        launch(1'b0, 15'h0001, 16'h0000, t0);
        wait_done(t0, ok, rel);
        n_chk++; if (!ok || rdata !== 16'h01C3) begin n_fail++; $display("FAIL lb_status got %h want 01c3", rdata); end
    endtask

    task automatic test_back_to_back;
        int t0, t1, rel, falls0, dones0, rise_old; bit ok;
        falls0 = cs_falls;
        dones0 = done_cnt;
        launch(1'b1, 15'h0005, 16'h1111, t0);
        while (cyc - t0 + 1 < 100) @(negedge clk);
        start = 1'b1; wr = 1'b0; addr = 15'h0007;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(t0, ok, rel);
        n_chk++; if (!ok || rel != 1 + 66*HP) begin n_fail++; $display("FAIL ign_done_cycle got %0d want %0d", rel, 1 + 66*HP); end
        n_chk++; if (cs_falls - falls0 != 1 || done_cnt - dones0 != 1) begin
            n_fail++; $display("FAIL ign_single got falls=%0d dones=%0d want 1 1", cs_falls - falls0, done_cnt - dones0);
        end
        n_chk++; if (last_frame !== 32'h80051111) begin n_fail++; $display("FAIL ign_frame got %h want 80051111", last_frame); end
        ref_regs[5] = 16'h1111;
        rise_old = cs_rise_cyc;
        // still inside the done cycle: this start must be accepted
        start = 1'b1; wr = 1'b0; addr = 15'h0005;
        @(posedge clk);
        #1 start = 1'b0;
        t1 = cyc;
        @(negedge clk);
        #1;
        n_chk++; if (cs !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_cs_fall got cs=%b busy=%b want 0 1", cs, busy); end
        n_chk++; if (cs_fall_cyc - rise_old != HP + 1) begin n_fail++; $display("FAIL b2b_gap got %0d want %0d", cs_fall_cyc - rise_old, HP + 1); end
        wait_done(t1, ok, rel);
        n_chk++; if (!ok || rdata !== ref_regs[5]) begin n_fail++; $display("FAIL b2b_rdata got %h want %h", rdata, ref_regs[5]); end
    endtask

    task automatic test_reset_mid;
        int t0, rel; bit ok; logic [15:0] cfg0;
        preset(0, 16'h0000);
        cfg0 = sregs[0];
        launch(1'b1, 15'h0000, 16'hFFFF, t0);
        while (cyc - t0 + 1 < 200) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if ({cs, sck, mosi, busy, done} !== 5'b10000 || rdata !== 16'h0) begin
            n_fail++; $display("FAIL rst_async got cs/sck/mosi/busy/done=%b rdata=%h want 10000 0000", {cs, sck, mosi, busy, done}, rdata);
        end
        repeat (3) @(negedge clk);
        #1;
        n_chk++; if (sregs[0] !== cfg0) begin n_fail++; $display("FAIL rst_cfg_kept got %h want %h", sregs[0], cfg0); end
        rst_n = 1'b1;
        launch(1'b1, 15'h0000, 16'h00C3, t0);
        wait_done(t0, ok, rel);
        ref_regs[0] = 16'h00C3;
        n_chk++; if (!ok || rel != 1 + 66*HP || rdata !== cfg0) begin
            n_fail++; $display("FAIL rst_next got cyc=%0d rdata=%h want %0d %h", rel, rdata, 1 + 66*HP, cfg0);
        end
        n_chk++; if (sregs[0] !== 16'h00C3) begin n_fail++; $display("FAIL rst_next_commit got %h want 00c3", sregs[0]); end
    endtask

    task automatic test_random;
        int t0, rel; bit ok; logic w; logic [7:0] a; logic [15:0] d, exp_rd; logic [31:0] exp_f;
        for (int i = 0; i < 6; i++) begin
            w      = 1'($urandom_range(0, 1));
            a      = 8'($urandom_range(0, 255));
            d      = 16'($urandom);
            exp_rd = ref_regs[a];
            exp_f  = {w, 7'h00, a, w ? d : 16'h0000};
            if (w) ref_regs[a] = d;
            launch(w, {7'h00, a}, d, t0);
            wait_done(t0, ok, rel);
            n_chk++; if (!ok || last_frame !== exp_f) begin n_fail++; $display("FAIL rnd%0d_frame got %h want %h", i, last_frame, exp_f); end
            n_chk++; if (rdata !== exp_rd) begin n_fail++; $display("FAIL rnd%0d_rdata got %h want %h", i, rdata, exp_rd); end
            n_chk++; if (sregs[a] !== ref_regs[a]) begin n_fail++; $display("FAIL rnd%0d_reg got %h want %h", i, sregs[a], ref_regs[a]); end
        end
    endtask

    task automatic test_hp4;
        int t0, rel, rises, falls; logic psck;
        @(negedge clk);
        start4 = 1'b1; wr4 = 1'b1; addr4 = 15'h0002; wdata4 = 16'h00A5;
        @(posedge clk);
        #1 start4 = 1'b0;
        t0 = cyc; rises = 0; falls = 0; psck = 1'b0; rel = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rel = cyc - t0 + 1;
            if (sck4 && !psck) begin
                n_chk++; if (rel != 1 + (2*rises + 1)*HP4) begin n_fail++; $display("FAIL hp4_rise%0d got %0d want %0d", rises, rel, 1 + (2*rises + 1)*HP4); end
                rises++;
            end
            if (!sck4 && psck) begin
                n_chk++; if (rel != 1 + (2*falls + 2)*HP4) begin n_fail++; $display("FAIL hp4_fall%0d got %0d want %0d", falls, rel, 1 + (2*falls + 2)*HP4); end
                falls++;
            end
            psck = sck4;
            if (done4) break;
        end
        n_chk++; if (done4 !== 1'b1 || rel != 265) begin n_fail++; $display("FAIL hp4_done got cyc=%0d done=%b want 265 1", rel, done4); end
        n_chk++; if (rises != 32) begin n_fail++; $display("FAIL hp4_rises got %0d want 32", rises); end
    endtask

    initial begin
        start = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        start4 = 1'b0; wr4 = 1'b0; addr4 = '0; wdata4 = '0;
        for (int i = 0; i < 256; i++) preset(i, 16'($urandom));
        test_reset;
        test_write;
        test_read;
        test_loopback;
        test_back_to_back;
        test_reset_mid;
        test_random;
        test_hp4;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
